rv32i_fwd_scoreboard: RTL and testbench
=======================================

# rv32i_fwd_scoreboard

Parametrised operand-forwarding and hazard-interlock unit for the RV32I pipeline, sitting between the register file and the ID/EX boundary. It tracks the destination registers of in-flight instructions in an internal tag pipeline and selects each source operand from the youngest producing stage or the register file. It stalls ID on load-use hazards, and it generalises the fixed three-stage EX/MEM/WB forwarding to any depth and read-port count. It also adds stall generation, bubble insertion and a stall performance counter.

## Interface
- XLEN, 32, datapath width
- NUM_RD_PORTS, 2, source operands per instruction (1..4)
- FWD_DEPTH, 3, tracked stages after ID; index 0 = EX, FWD_DEPTH-1 = WB (2..6)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  instruction in ID is valid
- id_rs_reg  in  NUM_RD_PORTS*5  source register numbers; port p at [5p+4:5p]
- id_rs_data_in  in  NUM_RD_PORTS*XLEN  register-file read data
- id_wb_en  in  1  ID instruction writes a register
- id_wb_reg  in  5  ID destination register
- id_is_load  in  1  ID instruction is a load; result is valid only from stage 1 (MEM) onward
- flush  in  1  squash the ID instruction, which enters EX as a bubble
- stage_data  in  FWD_DEPTH*XLEN  result currently held by stage k at [XLEN*k +: XLEN]
- stall  out  1  hold IF/ID this cycle (combinational)
- ex_valid  out  1  registered: EX holds a real instruction
- ex_rs_data  out  NUM_RD_PORTS*XLEN  registered resolved operands
- stall_count  out  32  saturating count of stall cycles

## Operation
- Tag pipeline: FWD_DEPTH entries of {valid, reg[4:0], is_load}.
  - Every cycle, entry k+1 <= entry k.
  - Entry 0 <= {id_valid & id_wb_en & (id_wb_reg!=0) & !flush & !stall, id_wb_reg, id_is_load}.
- Per port p, with r = id_rs_reg[p]:
  - r==0: operand is 0.
  - Otherwise find the lowest k with entry k valid and entry k reg==r.
    - Entry 0 with is_load: hazard, stall.
    - Any other hit: operand is stage_data[k].
    - No hit: operand is id_rs_data_in[p].
- Youngest hit always wins; older matching entries are ignored.
- stall = id_valid & !flush & (any port hazard).
- When stall=1: ex_valid <= 0 and entry 0 <= invalid (bubble); ex_rs_data holds its previous value. The upstream stages hold ID.
- When flush=1: no stall, ex_valid <= 0, bubble inserted.
- Otherwise: ex_valid <= id_valid and ex_rs_data <= resolved operands.
- stall_count increments on each cycle with stall=1 and saturates at 32'hFFFF_FFFF.

## Timing
- stall: combinational from ID inputs and tag state, same cycle.
- ex_valid and ex_rs_data: one-cycle latency from the ID inputs.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load sits in entry 1 and is forwarded from stage_data[1].
- Reset, applied asynchronously at any time including mid-stall: all tags invalid, ex_valid=0, ex_rs_data=0, stall_count=0. stall reads 0 during reset.
- Same register in several ports: each port resolves independently; a hazard on any port stalls.
- WB-stage hit (k=FWD_DEPTH-1): forwarded. This covers the register file's same-cycle write/read.

## Configuration
- RV32I_FWD_EN defined: full forwarding as above.
- RV32I_FWD_EN undefined: interlock-only mode.
  - stage_data is ignored.
  - Any valid tag hit on a nonzero source register in any entry raises stall.
  - The operand always comes from id_rs_data_in.
  - Tag shifting and the bubble rules are unchanged.

## Test plan
- **EX forward:** addi x5 (non-load) in entry 0 with stage_data[0]=32'h1234, ID reads x5 -> stall=0; next cycle ex_rs_data[0]=32'h1234, ex_valid=1.
- **Load-use:** load to x7 followed by a read of x7 -> stall=1 for one cycle, stall_count=1, ex_valid=0. Next cycle the operand equals stage_data[1] (32'hDEAD_BEEF).
- **Priority:** x3 in entries 0 and 2 with data 32'hA and 32'hB -> operand 32'hA.
- **x0 and flush:** rs=x0 with entry 0 tagged x0 -> operand 0, no stall. Flush during a would-be hazard -> stall=0, ex_valid=0.
- **Reset:** assert reset mid-stall -> outputs and stall_count are 0 immediately. After release, a no-hit read passes id_rs_data_in (32'h5555_AAAA) through.
- **Interlock mode:** with RV32I_FWD_EN undefined, a hit in entry 2 -> stall=1 until the tag leaves, three stall cycles for a back-to-back producer.

Source files
------------

// File: rtl/rv32i_fwd_scoreboard.sv
// Operand forwarding and hazard interlock between the register file and ID/EX.
// Define RV32I_FWD_EN for full forwarding; otherwise the unit is interlock-only.
module rv32i_fwd_scoreboard #(
   parameter int XLEN         = 32,
   parameter int NUM_RD_PORTS = 2,
   parameter int FWD_DEPTH    = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         id_valid,
   input  logic [NUM_RD_PORTS*5-1:0]    id_rs_reg,
   input  logic [NUM_RD_PORTS*XLEN-1:0] id_rs_data_in,
   input  logic                         id_wb_en,
   input  logic [4:0]                   id_wb_reg,
   input  logic                         id_is_load,
   input  logic                         flush,
   input  logic [FWD_DEPTH*XLEN-1:0]    stage_data,
   output logic                         stall,
   output logic                         ex_valid,
   output logic [NUM_RD_PORTS*XLEN-1:0] ex_rs_data,
   output logic [31:0]                  stall_count
);

   logic [FWD_DEPTH-1:0]          tag_valid_reg;
   logic [4:0]                    tag_rd_reg [FWD_DEPTH];
   logic [FWD_DEPTH-1:0]          tag_load_reg;
   logic                          ex_valid_reg;
   logic [NUM_RD_PORTS*XLEN-1:0]  ex_rs_data_reg;
   logic [31:0]                   stall_count_reg;

   logic [NUM_RD_PORTS-1:0]       port_hazard;
   logic [NUM_RD_PORTS*XLEN-1:0]  resolved;
   logic                          stall_int;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_port
         logic [4:0]           rs;
         logic [FWD_DEPTH-1:0] hit;
         logic                 haz;
         logic [XLEN-1:0]      op;

         assign rs = id_rs_reg[5*gi +: 5];

         for (genvar gk = 0; gk < FWD_DEPTH; gk++) begin : g_hit
            assign hit[gk] = tag_valid_reg[gk] && (tag_rd_reg[gk] == rs);
         end

`ifdef RV32I_FWD_EN
         // Scan from EX outward so the youngest producer shadows older ones.
         always_comb begin
            logic found;
            haz   = 1'b0;
            op    = id_rs_data_in[gi*XLEN +: XLEN];
            found = 1'b0;
            for (int k = 0; k < FWD_DEPTH; k++) begin
               if (!found && hit[k]) begin
                  found = 1'b1;
                  if (k == 0 && tag_load_reg[0]) haz = 1'b1;
                  else op = stage_data[k*XLEN +: XLEN];
               end
            end
            if (rs == 5'd0) begin
               haz = 1'b0;
               op  = '0;
            end
         end
`else
         always_comb begin
            haz = (rs != 5'd0) && (|hit);
            op  = (rs == 5'd0) ? '0 : id_rs_data_in[gi*XLEN +: XLEN];
         end
`endif

         assign port_hazard[gi]              = haz;
         assign resolved[gi*XLEN +: XLEN]    = op;
      end
   endgenerate

`ifndef RV32I_FWD_EN
   // Stage results and load flags only matter when forwarding is built in.
   logic unused_fwd;
   assign unused_fwd = ^{stage_data, tag_load_reg};
`endif

   assign stall_int = !reset && id_valid && !flush && (|port_hazard);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_valid_reg   <= '0;
         tag_load_reg    <= '0;
         for (int k = 0; k < FWD_DEPTH; k++) tag_rd_reg[k] <= 5'd0;
         ex_valid_reg    <= 1'b0;
         ex_rs_data_reg  <= '0;
         stall_count_reg <= '0;
      end else begin
         for (int k = FWD_DEPTH - 1; k > 0; k--) begin
            tag_valid_reg[k] <= tag_valid_reg[k-1];
            tag_rd_reg[k]    <= tag_rd_reg[k-1];
            tag_load_reg[k]  <= tag_load_reg[k-1];
         end
         // Stalled or flushed instructions enter EX as a bubble.
         tag_valid_reg[0] <= id_valid && id_wb_en && (id_wb_reg != 5'd0) && !flush && !stall_int;
         tag_rd_reg[0]    <= id_wb_reg;
         tag_load_reg[0]  <= id_is_load;

         if (stall_int || flush) begin
            ex_valid_reg <= 1'b0;
         end else begin
            ex_valid_reg   <= id_valid;
            ex_rs_data_reg <= resolved;
         end

         if (stall_int && (stall_count_reg != 32'hFFFF_FFFF))
            stall_count_reg <= stall_count_reg + 32'd1;
      end
   end

   assign stall       = stall_int;
   assign ex_valid    = ex_valid_reg;
   assign ex_rs_data  = ex_rs_data_reg;
   assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_rv32i_fwd_scoreboard.sv
// Self-checking bench for rv32i_fwd_scoreboard: directed scenarios plus random traffic
// against a tag-list reference model; follows RV32I_FWD_EN like the design.
module tb_rv32i_fwd_scoreboard;
   localparam int XLEN = 32;
   localparam int NP   = 2;
   localparam int D    = 3;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 id_valid;
   logic [NP*5-1:0]      id_rs_reg;
   logic [NP*XLEN-1:0]   id_rs_data_in;
   logic                 id_wb_en;
   logic [4:0]           id_wb_reg;
   logic                 id_is_load;
   logic                 flush;
   logic [D*XLEN-1:0]    stage_data;
   logic                 stall;
   logic                 ex_valid;
   logic [NP*XLEN-1:0]   ex_rs_data;
   logic [31:0]          stall_count;

   rv32i_fwd_scoreboard #(.XLEN(XLEN), .NUM_RD_PORTS(NP), .FWD_DEPTH(D)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_reg(id_rs_reg),
      .id_rs_data_in(id_rs_data_in), .id_wb_en(id_wb_en), .id_wb_reg(id_wb_reg),
      .id_is_load(id_is_load), .flush(flush), .stage_data(stage_data),
      .stall(stall), .ex_valid(ex_valid), .ex_rs_data(ex_rs_data),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   // Reference state: list of in-flight writers, youngest first.
   typedef struct {bit v; bit [4:0] r; bit ld;} tag_t;
   tag_t             m_tag [D];
   bit               m_ex_valid;
   logic [NP*XLEN-1:0] m_ex_data;
   bit               m_data_known;
   logic [31:0]      m_count;
   bit               last_stall;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_eval(output bit haz_any, output logic [NP*XLEN-1:0] ops);
      haz_any = 0;
      ops     = '0;
      for (int p = 0; p < NP; p++) begin
         logic [4:0]      r;
         logic [XLEN-1:0] op;
         int              youngest;
         r  = id_rs_reg[5*p +: 5];
         op = id_rs_data_in[p*XLEN +: XLEN];
         youngest = -1;
         for (int k = D - 1; k >= 0; k--)
            if (m_tag[k].v && m_tag[k].r == r) youngest = k;
         if (r == 0) begin
            op = '0;
         end else if (youngest >= 0) begin
`ifdef RV32I_FWD_EN
            if (youngest == 0 && m_tag[0].ld) haz_any = 1;
            else op = stage_data[youngest*XLEN +: XLEN];
`else
            haz_any = 1;
`endif
         end
         ops[p*XLEN +: XLEN] = op;
      end
   endfunction

   task automatic model_reset();
      for (int k = 0; k < D; k++) m_tag[k] = '{0, 5'd0, 0};
      m_ex_valid   = 0;
      m_ex_data    = '0;
      m_data_known = 1;
      m_count      = '0;
      last_stall   = 0;
   endtask

   // One clock: check combinational stall, clock, then check registered outputs.
   task automatic step(input string tag);
      bit                 haz;
      bit                 st;
      logic [NP*XLEN-1:0] ops;
      #1;
      model_eval(haz, ops);
      st = id_valid && !flush && haz;
      check({tag, ":stall"}, stall, st);
      @(posedge clk);
      for (int k = D - 1; k > 0; k--) m_tag[k] = m_tag[k-1];
      m_tag[0].v  = id_valid && id_wb_en && (id_wb_reg != 0) && !flush && !st;
      m_tag[0].r  = id_wb_reg;
      m_tag[0].ld = id_is_load;
      if (st || flush) begin
         m_ex_valid = 0;
         if (flush) m_data_known = 0;
      end else begin
         m_ex_valid   = id_valid;
         m_ex_data    = ops;
         m_data_known = 1;
      end
      if (st && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
      last_stall = st;
      #1;
      check({tag, ":ex_valid"}, ex_valid, m_ex_valid);
      if (m_data_known) check({tag, ":ex_rs_data"}, ex_rs_data, m_ex_data);
      check({tag, ":stall_count"}, stall_count, m_count);
      $display("[%0t] %s v=%0b rs=%h fl=%0b stall=%0b exv=%0b ex=%h cnt=%0d",
               $time, tag, id_valid, id_rs_reg, flush, st, ex_valid, ex_rs_data, stall_count);
   endtask

   // Step, then keep ID held while the model says it is stalled (bounded).
   task automatic issue(input string tag);
      int guard;
      step(tag);
      guard = 0;
      while (last_stall && guard < 8) begin
         step({tag, "+held"});
         guard++;
      end
      if (last_stall) check({tag, ":stall_bound"}, 1, 0);
   endtask

   task automatic set_id(input bit v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1,
                         input bit wen, input logic [4:0] wreg, input bit ld, input bit fl);
      id_valid      = v;
      id_rs_reg     = {rs1, rs0};
      id_rs_data_in = {d1, d0};
      id_wb_en      = wen;
      id_wb_reg     = wreg;
      id_is_load    = ld;
      flush         = fl;
   endtask

   initial begin
      int cnt_before;
      model_reset();
      reset = 1'b1;
      set_id(1, 5'd1, 5'd2, 32'h1111_1111, 32'h2222_2222, 1, 5'd1, 0, 0);
      stage_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      repeat (2) @(posedge clk);
      #1;
      check("rst:stall", stall, 0);
      check("rst:ex_valid", ex_valid, 0);
      check("rst:ex_rs_data", ex_rs_data, 0);
      check("rst:stall_count", stall_count, 0);
      @(negedge clk);
      reset = 1'b0;

      // EX forward: non-load writer of x5, then a reader of x5.
      set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd5, 0, 0);
      issue("exfwd_prod");
      stage_data[0 +: XLEN] = 32'h1234;
      set_id(1, 5'd5, 5'd0, 32'hBAD0_0005, 32'h0, 0, 5'd0, 0, 0);
      cnt_before = stall_count;
      issue("exfwd_use");
`ifdef RV32I_FWD_EN
      check("exfwd:operand", ex_rs_data[XLEN-1:0], 32'h1234);
      check("exfwd:no_stall", stall_count - cnt_before, 0);
`else
      check("interlock:operand", ex_rs_data[XLEN-1:0], 32'hBAD0_0005);
      check("interlock:three_stalls", stall_count - cnt_before, 3);
`endif

      // Load-use on x7.
      set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd7, 1, 0);
      issue("lduse_load");
      stage_data = {32'h0, 32'hDEAD_BEEF, 32'h0BAD_0BAD};
      cnt_before = stall_count;
      set_id(1, 5'd7, 5'd7, 32'hBAD0_0007, 32'hBAD1_0007, 0, 5'd0, 0, 0);
      issue("lduse_use");
`ifdef RV32I_FWD_EN
      check("lduse:operand", ex_rs_data, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
      check("lduse:one_stall", stall_count - cnt_before, 1);
`endif

      // Priority: x3 written at entries 2 and 0.
      set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd3, 0, 0);
      issue("prio_old");
      set_id(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
      issue("prio_gap");
      set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd3, 0, 0);
      issue("prio_new");
      stage_data = {32'hB, 32'h0, 32'hA};
      set_id(1, 5'd3, 5'd0, 32'hBAD0_0003, 0, 0, 5'd0, 0, 0);
      issue("prio_use");
`ifdef RV32I_FWD_EN
      check("prio:operand", ex_rs_data[XLEN-1:0], 32'hA);
`endif

      // x0: a write to x0 is never tracked, reading x0 yields zero.
      set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 1, 0);
      issue("x0_prod");
      set_id(1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hEEEE_EEEE, 0, 5'd0, 0, 0);
      issue("x0_use");

      // Flush during a would-be hazard.
      set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 1, 0);
      issue("flush_load");
      set_id(1, 5'd9, 5'd0, 32'h9, 0, 0, 5'd0, 0, 1);
      step("flush_use");

      // Reset asserted mid-stall.
      set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd10, 1, 0);
      issue("rst_load");
      set_id(1, 5'd10, 5'd0, 32'hA, 0, 0, 5'd0, 0, 0);
      #2;
      check("rst_mid:pre_stall", stall, 1);
      reset = 1'b1;
      #1;
      model_reset();
      check("rst_mid:stall", stall, 0);
      check("rst_mid:ex_valid", ex_valid, 0);
      check("rst_mid:ex_rs_data", ex_rs_data, 0);
      check("rst_mid:stall_count", stall_count, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      set_id(1, 5'd12, 5'd13, 32'h5555_AAAA, 32'h1357_9BDF, 0, 5'd0, 0, 0);
      issue("rst_pass");
      check("rst_pass:operand", ex_rs_data[XLEN-1:0], 32'h5555_AAAA);

      // Random traffic over a small register set so hits are frequent.
      for (int i = 0; i < 400; i++) begin
         if (!last_stall) begin
            set_id(($urandom_range(0, 99) < 85),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom, $urandom,
                   $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
         end
         for (int k = 0; k < D; k++) stage_data[k*XLEN +: XLEN] = $urandom;
         step("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
